// File: rtl/ctrl_seq_param_if.sv
// ctrl_seq_param_if: instruction handshake and datapath control bundle for ctrl_seq_param.
interface ctrl_seq_param_if #(
    parameter int N_REG = 2
) ();
    localparam int SEL_W = N_REG > 1 ? $clog2(N_REG) : 1;
    logic             start;
    logic [SEL_W+2:0] instruction;
    logic             oe_memo;
    logic             oe_alu;
    logic             oe_port_n;
    logic [N_REG-1:0] reg_oe;
    logic [N_REG-1:0] reg_ld;
    logic             out_ld;
    logic             r_w;
    logic             mem_we;
    logic             busy;
    logic             done;
    logic             err;
    logic             halted;
    modport master (
        output start, instruction,
        input  oe_memo, oe_alu, oe_port_n, reg_oe, reg_ld, out_ld, r_w, mem_we,
               busy, done, err, halted
    );
    modport slave (
        input  start, instruction,
        output oe_memo, oe_alu, oe_port_n, reg_oe, reg_ld, out_ld, r_w, mem_we,
               busy, done, err, halted
    );
endinterface

// File: rtl/ctrl_seq_param.sv
// ctrl_seq_param: sequences one bus-transfer instruction through SETUP/STROBE/HOLD,
// driving bus enables and load/write strobes, with start/busy/done handshake and HALT.
module ctrl_seq_param #(
    parameter int N_REG     = 2,
    parameter int SETUP_CYC = 1,
    parameter int STRB_CYC  = 1
) (
    input logic           clk,
    input logic           clear,
    ctrl_seq_param_if.slave bus
);
    localparam int SEL_W = N_REG > 1 ? $clog2(N_REG) : 1;
    localparam logic [2:0] OP_NOP = 3'd0, OP_LDM = 3'd1, OP_LDA = 3'd2, OP_LDP = 3'd3,
                           OP_STM = 3'd4, OP_OUTA = 3'd5, OP_OUTP = 3'd6, OP_HALT = 3'd7;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, HALT} state_t;

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [SEL_W+2:0] ins, ins_nx;
    logic [2:0]       op;
    logic [N_REG-1:0] one_hot;
    logic             src, strb, done_nx, err_nx;

    function automatic logic illegal(input logic [SEL_W+2:0] i);
        return i[SEL_W+2:SEL_W] inside {OP_LDM, OP_LDA, OP_LDP, OP_STM} &&
               int'(i[SEL_W-1:0]) >= N_REG;
    endfunction

    function automatic logic active(input logic [SEL_W+2:0] i);
        return i[SEL_W+2:SEL_W] != OP_NOP && i[SEL_W+2:SEL_W] != OP_HALT && !illegal(i);
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ins_nx   = ins;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                ins_nx   = bus.instruction;
                cnt_nx   = '0;
                state_nx = bus.instruction[SEL_W+2:SEL_W] == OP_HALT ? HALT :
                           active(bus.instruction) ? SETUP : HOLD;
            end
            SETUP: begin
                state_nx = cnt == 4'(SETUP_CYC - 1) ? STROBE : SETUP;
                cnt_nx   = cnt == 4'(SETUP_CYC - 1) ? 4'd0 : cnt + 4'd1;
            end
            STROBE: begin
                state_nx = cnt == 4'(STRB_CYC - 1) ? HOLD : STROBE;
                cnt_nx   = cnt == 4'(STRB_CYC - 1) ? 4'd0 : cnt + 4'd1;
            end
            HOLD: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
                err_nx   = illegal(ins);
            end
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    assign op      = ins_nx[SEL_W+2:SEL_W];
    assign one_hot = N_REG'(1) << ins_nx[SEL_W-1:0];
    assign src     = active(ins_nx) && state_nx inside {SETUP, STROBE, HOLD};
    assign strb    = active(ins_nx) && state_nx == STROBE;

    always_ff @(posedge clk) begin
        if (clear) begin
            state         <= IDLE;
            cnt           <= '0;
            ins           <= '0;
            bus.oe_memo   <= 1'b0;
            bus.oe_alu    <= 1'b0;
            bus.oe_port_n <= 1'b1;
            bus.reg_oe    <= '0;
            bus.reg_ld    <= '0;
            bus.out_ld    <= 1'b0;
            bus.r_w       <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.halted    <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            ins           <= ins_nx;
            bus.oe_memo   <= src && op == OP_LDM;
            bus.oe_alu    <= src && (op == OP_LDA || op == OP_OUTA);
            bus.oe_port_n <= !(src && (op == OP_LDP || op == OP_OUTP));
            bus.reg_oe    <= src && op == OP_STM ? one_hot : '0;
            bus.reg_ld    <= strb && op inside {OP_LDM, OP_LDA, OP_LDP} ? one_hot : '0;
            bus.out_ld    <= strb && (op == OP_OUTA || op == OP_OUTP);
            bus.r_w       <= src && op == OP_STM;
            bus.mem_we    <= strb && op == OP_STM;
            bus.busy      <= state_nx != IDLE;
            bus.done      <= done_nx;
            bus.err       <= err_nx;
            bus.halted    <= state_nx == HALT;
        end
    end
endmodule

// File: tb/tb_ctrl_seq_param.sv
// tb_ctrl_seq_param: directed checks of ctrl_seq_param in three parameterisations.
module tb_ctrl_seq_param;
    logic clk = 1'b0;
    logic clear = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_seq_param_if #(.N_REG(2)) a_if ();
    ctrl_seq_param_if #(.N_REG(2)) b_if ();
    ctrl_seq_param_if #(.N_REG(3)) c_if ();

    ctrl_seq_param #(.N_REG(2), .SETUP_CYC(1), .STRB_CYC(1)) dut_a (.clk(clk), .clear(clear), .bus(a_if));
    ctrl_seq_param #(.N_REG(2), .SETUP_CYC(3), .STRB_CYC(2)) dut_b (.clk(clk), .clear(clear), .bus(b_if));
    ctrl_seq_param #(.N_REG(3), .SETUP_CYC(1), .STRB_CYC(1)) dut_c (.clk(clk), .clear(clear), .bus(c_if));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_if.start = 0; a_if.instruction = '0;
        b_if.start = 0; b_if.instruction = '0;
        c_if.start = 0; c_if.instruction = '0;
        tick(); tick();
        clear = 0;
        chk("rst_port_n", a_if.oe_port_n, 1);
        chk("rst_memo", a_if.oe_memo, 0);
        chk("rst_busy", a_if.busy, 0);
        chk("rst_done", a_if.done, 0);
        chk("rst_reg_ld", a_if.reg_ld, 0);
        chk("rst_halted", b_if.halted, 0);

        // LDM sel=1, defaults
        a_if.instruction = {3'b001, 1'b1};
        a_if.start = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            a_if.start = 0;
            chk($sformatf("ldm_memo_%0d", i), a_if.oe_memo, (i >= 1 && i <= 3) ? 1 : 0);
            chk($sformatf("ldm_ld_%0d", i), a_if.reg_ld, (i == 2) ? 2 : 0);
            chk($sformatf("ldm_done_%0d", i), a_if.done, (i == 4) ? 1 : 0);
            chk($sformatf("ldm_busy_%0d", i), a_if.busy, (i <= 3) ? 1 : 0);
        end

        // STM sel=0 with SETUP_CYC=3, STRB_CYC=2
        b_if.instruction = {3'b100, 1'b0};
        b_if.start = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            b_if.start = 0;
            chk($sformatf("stm_rw_%0d", i), b_if.r_w, (i <= 6) ? 1 : 0);
            chk($sformatf("stm_oe_%0d", i), b_if.reg_oe, (i <= 6) ? 1 : 0);
            chk($sformatf("stm_we_%0d", i), b_if.mem_we, (i == 4 || i == 5) ? 1 : 0);
            chk($sformatf("stm_done_%0d", i), b_if.done, (i == 7) ? 1 : 0);
        end

        // back-to-back LDP sel=0 then OUTA with start held
        a_if.instruction = {3'b011, 1'b0};
        a_if.start = 1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) a_if.instruction = {3'b101, 1'b0};
            chk($sformatf("b2b_port_%0d", i), a_if.oe_port_n, (i <= 3) ? 0 : 1);
            chk($sformatf("b2b_alu_%0d", i), a_if.oe_alu, (i >= 5 && i <= 7) ? 1 : 0);
            chk($sformatf("b2b_ld_%0d", i), a_if.reg_ld, (i == 2) ? 1 : 0);
            chk($sformatf("b2b_out_%0d", i), a_if.out_ld, (i == 6) ? 1 : 0);
            chk($sformatf("b2b_done_%0d", i), a_if.done, (i == 4 || i == 8) ? 1 : 0);
            chk($sformatf("b2b_excl_%0d", i), a_if.oe_alu & ~a_if.oe_port_n, 0);
            if (i == 5) a_if.start = 0;
        end

        // N_REG=3: illegal select, NOP, then legal LDA sel=2
        c_if.instruction = {3'b010, 2'b11};
        c_if.start = 1;
        tick();
        c_if.start = 0;
        chk("ill_busy", c_if.busy, 1);
        chk("ill_alu", c_if.oe_alu, 0);
        tick();
        chk("ill_done", c_if.done, 1);
        chk("ill_err", c_if.err, 1);
        chk("ill_ld", c_if.reg_ld, 0);
        tick();
        chk("ill_err_off", c_if.err, 0);
        c_if.instruction = {3'b000, 2'b00};
        c_if.start = 1;
        tick();
        c_if.start = 0;
        chk("nop_port", c_if.oe_port_n, 1);
        tick();
        chk("nop_done", c_if.done, 1);
        chk("nop_err", c_if.err, 0);
        c_if.instruction = {3'b010, 2'b10};
        c_if.start = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            c_if.start = 0;
            chk($sformatf("lda3_alu_%0d", i), c_if.oe_alu, (i <= 3) ? 1 : 0);
            chk($sformatf("lda3_ld_%0d", i), c_if.reg_ld, (i == 2) ? 4 : 0);
            chk($sformatf("lda3_err_%0d", i), c_if.err, 0);
        end

        // HALT, start ignored, clear exits
        a_if.instruction = {3'b111, 1'b0};
        a_if.start = 1;
        tick();
        a_if.start = 0;
        chk("halt_halted", a_if.halted, 1);
        chk("halt_busy", a_if.busy, 1);
        a_if.instruction = {3'b001, 1'b0};
        a_if.start = 1;
        tick();
        a_if.start = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("halt_memo_%0d", i), a_if.oe_memo, 0);
            chk($sformatf("halt_done_%0d", i), a_if.done, 0);
            chk($sformatf("halt_hold_%0d", i), a_if.halted, 1);
        end
        clear = 1;
        tick();
        clear = 0;
        chk("hclr_halted", a_if.halted, 0);
        chk("hclr_busy", a_if.busy, 0);
        chk("hclr_port", a_if.oe_port_n, 1);
        a_if.start = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            a_if.start = 0;
            chk($sformatf("hldm_ld_%0d", i), a_if.reg_ld, (i == 2) ? 1 : 0);
            chk($sformatf("hldm_done_%0d", i), a_if.done, (i == 4) ? 1 : 0);
        end

        // clear during STROBE
        a_if.instruction = {3'b001, 1'b0};
        a_if.start = 1;
        tick();
        a_if.start = 0;
        tick();
        chk("cstb_ld", a_if.reg_ld, 1);
        clear = 1;
        tick();
        clear = 0;
        chk("cstb_ld_off", a_if.reg_ld, 0);
        chk("cstb_memo", a_if.oe_memo, 0);
        chk("cstb_busy", a_if.busy, 0);
        chk("cstb_port", a_if.oe_port_n, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("cstb_done_%0d", i), a_if.done, 0);
            chk($sformatf("cstb_ld2_%0d", i), a_if.reg_ld, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
